// File: rtl/mips_debug_pkg.sv
// Shared definitions for the MIPS debug path: loader state encoding and
// program-loader defaults.
package mips_debug_pkg;

  typedef logic [2:0] loader_state_t;

  localparam loader_state_t ST_IDLE    = 3'd0;
  localparam loader_state_t ST_COLLECT = 3'd1;
  localparam loader_state_t ST_WRITE   = 3'd2;
  localparam loader_state_t ST_DONE    = 3'd3;
  localparam loader_state_t ST_ERROR   = 3'd4;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
  // About four byte-times of 9600-baud traffic at a 50 MHz clock.
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 32'd200000;

  function automatic logic is_busy_state(input loader_state_t s);
    return (s == ST_COLLECT) || (s == ST_WRITE);
  endfunction

endpackage

// File: rtl/byte_word_assembler.sv
// Little-endian byte-to-word assembler: byte lanes fill from bit 0 upward.
// o_word/o_word_complete reflect the byte being accepted this cycle.
module byte_word_assembler #(
  parameter int NBITS     = 32,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_load,
  input  logic                 i_clear,
  input  logic [DATA_BITS-1:0] i_byte,
  output logic [NBITS-1:0]     o_word,
  output logic                 o_word_complete,
  output logic                 o_partial
);

  localparam int LANES = NBITS / DATA_BITS;
  localparam int IDXW  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LANES - 1);

  logic [NBITS-1:0] word_q, word_d;
  logic [IDXW-1:0]  idx_q, idx_d;

  // Next-state: clear wins over a simultaneous byte.
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (i_clear) begin
      word_d = '0;
      idx_d  = '0;
    end else if (i_load) begin
      word_d[idx_q*DATA_BITS +: DATA_BITS] = i_byte;
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDXW'(1);
    end else begin
      word_d = word_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  assign o_word          = word_d;
  assign o_word_complete = i_load && !i_clear && (idx_q == LAST_IDX);
  assign o_partial       = (idx_q != '0);

endmodule

// File: rtl/mips_instr_loader.sv
// UART-fed program loader driving the MIPS instruction-memory debug port.
// Optional inter-byte timeout and ERROR state: MIPS_INSTR_LOADER_TIMEOUT_EN.
module mips_instr_loader
  import mips_debug_pkg::*;
#(
  parameter int NBITS          = 32,
  parameter int DATA_BITS      = 8,
  parameter int CELDAS_I       = 64,
  parameter logic [NBITS-1:0] HALT_WORD = NBITS'(HALT_WORD_DEFAULT),
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_start,
  input  logic                        i_rx_ready,
  input  logic [DATA_BITS-1:0]        i_rx_data,
  output logic [$clog2(CELDAS_I)-1:0] o_instr_sel,
  output logic [NBITS-1:0]            o_instr_dato,
  output logic                        o_instr_write,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_error,
  output logic [$clog2(CELDAS_I):0]   o_word_count
);

  localparam int SELW = $clog2(CELDAS_I);
  localparam int CNTW = SELW + 1;

  loader_state_t    state_q, state_d;
  logic [SELW-1:0]  addr_q, addr_d, sel_q, sel_d;
  logic [NBITS-1:0] dato_q, dato_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             write_q, write_d, busy_q, busy_d, done_q, done_d;

  logic             asm_load, asm_clear, asm_complete, asm_partial, tmo_fire;
  logic [NBITS-1:0] asm_word;

`ifdef MIPS_INSTR_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          error_q, error_d;
  assign tmo_fire = (state_q == ST_COLLECT) && asm_partial && !i_rx_ready &&
                    (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign o_error  = error_q;
`else
  wire unused_cfg = asm_partial ^ (TIMEOUT_CYCLES != 0);
  assign tmo_fire = 1'b0;
  assign o_error  = 1'b0;
`endif

  // A byte that lands in the WRITE cycle already belongs to the next word.
  assign asm_load  = i_rx_ready && !i_start && is_busy_state(state_q);
  assign asm_clear = i_start || tmo_fire;

  byte_word_assembler #(.NBITS(NBITS), .DATA_BITS(DATA_BITS)) u_asm (
    .clk             (clk),
    .reset           (reset),
    .i_load          (asm_load),
    .i_clear         (asm_clear),
    .i_byte          (i_rx_data),
    .o_word          (asm_word),
    .o_word_complete (asm_complete),
    .o_partial       (asm_partial)
  );

  // Loader FSM, address/count bookkeeping and write-port staging.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    dato_d  = dato_q;
    count_d = count_q;
    done_d  = done_q;
    write_d = 1'b0;
`ifdef MIPS_INSTR_LOADER_TIMEOUT_EN
    error_d = error_q;
    tmo_d   = ((state_q == ST_COLLECT) && asm_partial && !i_rx_ready && !i_start)
              ? tmo_q + TW'(1) : '0;
`endif
    if (i_start) begin
      state_d = ST_COLLECT;
      addr_d  = '0;
      count_d = '0;
      done_d  = 1'b0;
`ifdef MIPS_INSTR_LOADER_TIMEOUT_EN
      error_d = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE:    state_d = ST_IDLE;
        ST_COLLECT: begin
          if (asm_complete) begin
            state_d = ST_WRITE;
            write_d = 1'b1;
            sel_d   = addr_q;
            dato_d  = asm_word;
            count_d = count_q + CNTW'(1);
          end else if (tmo_fire) begin
            state_d = ST_ERROR;
`ifdef MIPS_INSTR_LOADER_TIMEOUT_EN
            error_d = 1'b1;
            tmo_d   = '0;
`endif
          end else begin
            state_d = ST_COLLECT;
          end
        end
        ST_WRITE: begin
          addr_d = (addr_q == SELW'(CELDAS_I - 1)) ? addr_q : addr_q + SELW'(1);
          if ((dato_q == HALT_WORD) || (count_q == CNTW'(CELDAS_I))) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_COLLECT;
          end
        end
        ST_DONE:  state_d = ST_DONE;
        ST_ERROR: state_d = ST_ERROR;
        default:  state_d = ST_IDLE;
      endcase
    end
    busy_d = is_busy_state(state_d);
  end

  // Registers; every output comes straight from a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      sel_q   <= '0;
      dato_q  <= '0;
      count_q <= '0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MIPS_INSTR_LOADER_TIMEOUT_EN
      error_q <= 1'b0;
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      dato_q  <= dato_d;
      count_q <= count_d;
      write_q <= write_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MIPS_INSTR_LOADER_TIMEOUT_EN
      error_q <= error_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign o_instr_sel   = sel_q;
  assign o_instr_dato  = dato_q;
  assign o_instr_write = write_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_word_count  = count_q;

endmodule
